// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_ctrl_pkg : opcodes, FSM state codes and mux/ALU encodings for the MIPS core
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef logic [3:0] state_t;

  localparam state_t S_RESET  = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_MEMADR = 4'd3;
  localparam state_t S_MEMRD  = 4'd4;
  localparam state_t S_MEMWB  = 4'd5;
  localparam state_t S_MEMWR  = 4'd6;
  localparam state_t S_RTYPE  = 4'd7;
  localparam state_t S_ALUWB  = 4'd8;
  localparam state_t S_BRANCH = 4'd9;
  localparam state_t S_IEXEC  = 4'd10;
  localparam state_t S_IWB    = 4'd11;
  localparam state_t S_JUMP   = 4'd12;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic op_is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  function automatic logic op_is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_BEQ)  ||
           (op == OP_BNE)   || (op == OP_ADDI) || (op == OP_ANDI) ||
           (op == OP_ORI)   || (op == OP_XORI) || (op == OP_LW)   ||
           (op == OP_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_out_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_ctrl_out_decode : combinational state/op to datapath-strobe decoding
// Rev 1.0
// ---------------------------------------------------------------------------
module mips_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_en_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       zero_ext_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       illegal_op_o
);

  logic pc_write;
  logic branch;
  logic bne_sel;

  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_src_o     = PC_SRC_ALU;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = ALUB_REG;
    alu_op_o     = ALU_OP_ADD;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    illegal_op_o = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    bne_sel      = 1'b0;
    // The IR is only trustworthy from DECODE onwards.
    zero_ext_o   = (state_i != S_RESET) && (state_i != S_FETCH) && op_is_zero_ext(op_i);

    case (state_i)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = ALUB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write    = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o  = ALUB_IMM_SH2;
        illegal_op_o = !op_is_supported(op_i);
      end
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUB_IMM;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_RTYPE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_SUB;
        branch      = 1'b1;
        pc_src_o    = PC_SRC_ALUOUT;
        bne_sel     = (op_i == OP_BNE);
      end
      S_IEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUB_IMM;
        alu_op_o    = (op_i == OP_ADDI) ? ALU_OP_ADD : ALU_OP_IMM;
      end
      S_IWB: begin
        reg_write_o = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src_o = PC_SRC_JUMP;
      end
      default: begin
      end
    endcase

    pc_en_o = pc_write | (branch & (zero_i ^ bne_sel));
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl : multicycle MIPS main controller (state register + next state)
// Rev 1.0
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       zero_ext,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_RTYPE;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IEXEC;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTYPE:  state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctrl_out_decode u_out_decode (
    .state_i      (state_q),
    .op_i         (op),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_write_o  (mem_write),
    .iord_o       (iord),
    .ir_write_o   (ir_write),
    .pc_en_o      (pc_en),
    .pc_src_o     (pc_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .zero_ext_o   (zero_ext),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .illegal_op_o (illegal_op)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl : self-checking bench for the multicycle MIPS controller
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       zero_ext;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         fw;
    int         mw;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, zero_ext, reg_dst, mem_to_reg, reg_write, illegal_op;
  outs_t      cur;

  int tests_run = 0;
  int tests_failed = 0;
  int nonfetch = 0;

  always #5 clk = ~clk;

  assign cur = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
                alu_src_b, alu_op, zero_ext, reg_dst, mem_to_reg, reg_write, illegal_op};

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .zero_ext   (zero_ext),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal_op (illegal_op)
  );

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                     6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b000010};
  endfunction

  // Expected strobes for one named phase of an instruction, straight from the control table.
  function automatic outs_t model(input string ph, input logic [5:0] o,
                                 input logic z, input logic r);
    outs_t e = '0;
    if (ph != "FETCH" && ph != "RESET")
      e.zero_ext = (o == 6'b001100) || (o == 6'b001101) || (o == 6'b001110);
    case (ph)
      "FETCH":  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = r; e.pc_en = r; end
      "DECODE": begin e.alu_src_b = 2'b11; e.illegal_op = !legal(o); end
      "MEMADR": begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      "MEMRD":  begin e.mem_req = 1; e.iord = 1; end
      "MEMWB":  begin e.reg_write = 1; e.mem_to_reg = 1; end
      "MEMWR":  begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; end
      "RTYPE":  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      "ALUWB":  begin e.reg_write = 1; e.reg_dst = 1; end
      "BRANCH": begin
        e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01;
        e.pc_en = (o == 6'b000101) ? !z : z;
      end
      "IEXEC":  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = (o == 6'b001000) ? 2'b00 : 2'b11; end
      "IWB":    e.reg_write = 1;
      "JUMP":   begin e.pc_en = 1; e.pc_src = 2'b10; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b required %b (op=%b zero=%b rdy=%b)", name, got, exp, op, zero, mem_ready);
    end
  endtask

  task automatic step(input string ph, input logic [5:0] o, input logic z, input logic r);
    @(posedge clk);
    #1;
    op = o; zero = z; mem_ready = r;
    #1;
    if (!(mem_req && !iord && !mem_write)) nonfetch++;
    check(ph, cur, model(ph, o, z, r));
  endtask

  task automatic mem_phase(input string ph, input logic [5:0] o, input logic z, input int waits);
    for (int i = 0; i < waits; i++) step(ph, o, z, 1'b0);
    step(ph, o, z, 1'b1);
  endtask

  // Expands one instruction into its phase sequence and checks every cycle.
  task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
    nonfetch = 0;
    mem_phase("FETCH", o, z, fw);
    step("DECODE", o, z, rbit());
    if (o == 6'b100011) begin
      step("MEMADR", o, z, rbit());
      mem_phase("MEMRD", o, z, mw);
      step("MEMWB", o, z, rbit());
    end else if (o == 6'b101011) begin
      step("MEMADR", o, z, rbit());
      mem_phase("MEMWR", o, z, mw);
    end else if (o == 6'b000000) begin
      step("RTYPE", o, z, rbit());
      step("ALUWB", o, z, rbit());
    end else if (o == 6'b000100 || o == 6'b000101) begin
      step("BRANCH", o, z, rbit());
    end else if (o inside {6'b001000, 6'b001100, 6'b001101, 6'b001110}) begin
      step("IEXEC", o, z, rbit());
      step("IWB", o, z, rbit());
    end else if (o == 6'b000010) begin
      step("JUMP", o, z, rbit());
    end
  endtask

  vec_t vecs[$];
  logic [5:0] ops[10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                          6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b000010};

  initial begin
    vecs.push_back('{6'b100011, 1'b0, 0, 0, 5});
    vecs.push_back('{6'b100011, 1'b0, 0, 2, 7});
    vecs.push_back('{6'b100011, 1'b1, 1, 0, 6});
    vecs.push_back('{6'b101011, 1'b0, 0, 0, 4});
    vecs.push_back('{6'b101011, 1'b0, 0, 3, 7});
    vecs.push_back('{6'b000000, 1'b0, 0, 0, 4});
    vecs.push_back('{6'b001000, 1'b0, 0, 0, 4});
    vecs.push_back('{6'b001100, 1'b0, 0, 0, 4});
    vecs.push_back('{6'b001101, 1'b1, 0, 0, 4});
    vecs.push_back('{6'b001110, 1'b0, 0, 0, 4});
    vecs.push_back('{6'b000100, 1'b1, 0, 0, 3});
    vecs.push_back('{6'b000100, 1'b0, 0, 0, 3});
    vecs.push_back('{6'b000101, 1'b0, 0, 0, 3});
    vecs.push_back('{6'b000101, 1'b1, 0, 0, 3});
    vecs.push_back('{6'b000010, 1'b0, 2, 0, 5});
    vecs.push_back('{6'b111111, 1'b0, 0, 0, 2});
    vecs.push_back('{6'b001111, 1'b0, 0, 0, 2});

    rst_n = 1'b0; op = 6'b001101; zero = 1'b1; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 check("reset_hold", cur, '0);
    @(posedge clk);
    #2 check("reset_hold2", cur, '0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].z, vecs[i].fw, vecs[i].mw);
      tests_run++;
      if (nonfetch + vecs[i].fw + 1 != vecs[i].lat) begin
        tests_failed++;
        $display("FAIL latency[%0d] op=%b: got %0d cycles required %0d",
                 i, vecs[i].op, nonfetch + vecs[i].fw + 1, vecs[i].lat);
      end
    end

    // Reset asserted while a store is stalled waiting on memory.
    step("FETCH", 6'b101011, 1'b0, 1'b1);
    step("DECODE", 6'b101011, 1'b0, 1'b1);
    step("MEMADR", 6'b101011, 1'b0, 1'b1);
    step("MEMWR", 6'b101011, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_access", cur, '0);
    @(posedge clk);
    #2 check("rst_mid_access_hold", cur, '0);
    rst_n = 1'b1;
    run_instr(6'b101011, 1'b0, 0, 1);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] o;
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      run_instr(o, rbit(), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
